blk_431c31: RTL and testbench
=============================

INPUT -- requirements
Module: Input

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; ports are named clk and rst as in the codebase.
REQ-002 Parameter PASSWORD, default 12'h080, SHALL hold the unlock code {digit2, digit1, digit0}, each digit BCD 0-9.
REQ-003 Parameter MOVE_CYCLES, default 8, SHALL set the motor run time in clk cycles; legal range 1-255.
REQ-004 Parameter MAX_FAILS, default 3, SHALL set the number of wrong codes that raises the alarm; legal range 1-7.
REQ-005 clk  input  1  system clock; all state changes on the rising edge.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 Left, Right  input  1 each  move the cursor; synchronous to clk, already debounced.
REQ-008 Up, Down  input  1 each  increment or decrement the digit under the cursor; synchronous, debounced.
REQ-009 Enter  input  1  submit the code, or close the lock when it is open.
REQ-010 Value0, Value1, Value2  output  4 each  registered BCD digits at cursor positions 0, 1, 2.
REQ-011 Motor  output  3  registered motor command: 001 open-drive, 010 close-drive, 100 alarm, 000 idle.
REQ-012 Lock  output  1  registered; 1 = locked, 0 = unlocked.

Function
REQ-013 Each button SHALL act once per rising edge (sampled 1 now, 0 in the previous cycle); holding a button SHALL NOT repeat the action.
REQ-014 If several button edges occur in one cycle, only the highest-priority one SHALL act; priority is Enter > Up > Down > Right > Left.
REQ-015 Cursor is 2 bits with values 0-2; Right SHALL step it 0->1->2->0 and Left SHALL step it 0->2->1->0.
REQ-016 Up SHALL set the selected digit to (d+1) mod 10 (9 wraps to 0); Down SHALL set it to (d+9) mod 10 (0 wraps to 9).
REQ-017 The FSM SHALL have the states LOCKED, OPENING, OPEN, CLOSING and ALARM.
REQ-018 Cursor moves and digit edits SHALL take effect only in LOCKED; in every other state they SHALL be ignored.
REQ-019 LOCKED outputs: Lock=1, Motor=000.
REQ-020 In LOCKED, Enter with {Value2,Value1,Value0}==PASSWORD SHALL go to OPENING and clear the fail counter.
REQ-021 In LOCKED, Enter with a mismatch SHALL increment the fail counter, clear all digits to 0, keep the cursor, and stay in LOCKED.
REQ-022 If the incremented fail counter reaches MAX_FAILS, the FSM SHALL go to ALARM instead of staying in LOCKED.
REQ-023 OPENING outputs: Motor=001, Lock=1; after MOVE_CYCLES cycles in this state it SHALL go to OPEN.
REQ-024 OPEN outputs: Motor=000, Lock=0; Enter SHALL go to CLOSING.
REQ-025 CLOSING outputs: Motor=010, Lock=1; after MOVE_CYCLES cycles it SHALL go to LOCKED, clear all digits, and set the cursor to 0.
REQ-026 ALARM outputs: Motor=100, Lock=1; ALARM SHALL be left only by reset.
REQ-027 Outputs SHALL update on the clock edge after the triggering button edge (1-cycle latency); Lock and Motor SHALL change in the same cycle as the state.

Reset
REQ-028 rst=0 SHALL immediately force state=LOCKED, cursor=0, Value0-2=0, fail counter=0, move timer=0, edge-detect registers=0, Motor=000 and Lock=1, including mid-motion.
REQ-029 After rst is released, the first rising edge SHALL sample the buttons normally, with no spurious edge.

Verification
REQ-030 Cursor wrap: after reset, press Right x5 then Left x3, then Up once -> Value2=1, other digits 0.
REQ-031 Digit wrap: at cursor 1, press Up x2 then Down x4 -> Value1 goes 1, 2, 1, 0, 9, 8.
REQ-032 Wrong code: Enter with 000 -> Lock stays 1, Motor=000, digits cleared, cursor unchanged.
REQ-033 Unlock cycle: digits 0,8,0 then Enter -> Motor=001 for 8 cycles, then Lock=0 and Motor=000; Enter -> Motor=010 for 8 cycles, then Lock=1 and digits=0.
REQ-034 Alarm: three wrong Enters -> Motor=100 and buttons ignored; assert rst=0 -> Motor=000, Lock=1.
REQ-035 Simultaneous and held buttons: Up and Right high together for 3 cycles -> digit +1 once, cursor unchanged.

Source files
------------

// File: rtl/blk_431c31.sv
// Keypad lock controller: three-digit BCD code entry with cursor, motor open/close
// sequencing, and an alarm that latches after repeated wrong codes.
module blk_431c31 #(
  parameter logic [11:0] PASSWORD    = 12'h080,
  parameter int          MOVE_CYCLES = 8,
  parameter int          MAX_FAILS   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Left,
  input  logic       Right,
  input  logic       Up,
  input  logic       Down,
  input  logic       Enter,
  output logic [3:0] Value0,
  output logic [3:0] Value1,
  output logic [3:0] Value2,
  output logic [2:0] Motor,
  output logic       Lock
);

  // state      | meaning
  // S_LOCKED   | bolt closed, code entry active
  // S_OPENING  | motor driving open for MOVE_CYCLES cycles
  // S_OPEN     | bolt open, waiting for Enter to close
  // S_CLOSING  | motor driving closed for MOVE_CYCLES cycles
  // S_ALARM    | too many wrong codes, exits only through reset
  typedef enum logic [2:0] {
    S_LOCKED  = 3'd0,
    S_OPENING = 3'd1,
    S_OPEN    = 3'd2,
    S_CLOSING = 3'd3,
    S_ALARM   = 3'd4
  } state_t;

  localparam logic [7:0] MOVE_LOAD  = 8'(MOVE_CYCLES - 1);
  localparam logic [2:0] FAIL_LIMIT = 3'(MAX_FAILS);

  state_t      state, state_nxt;
  logic [4:0]  btn, btn_prev, rise;
  logic        act_enter, act_up, act_down, act_right, act_left;
  logic [1:0]  cursor;
  logic [3:0]  digit [3];
  logic [3:0]  sel_digit, digit_inc, digit_dec;
  logic [2:0]  fail_cnt, fail_inc;
  logic [7:0]  timer;
  logic        code_ok, fail_hit, timer_done, load_timer;
  logic [2:0]  motor_nxt;
  logic        lock_nxt;

  assign btn  = {Enter, Up, Down, Right, Left};
  assign rise = btn & ~btn_prev;

  // Only the highest-priority fresh edge acts in a given cycle.
  assign act_enter = rise[4];
  assign act_up    = rise[3] & ~rise[4];
  assign act_down  = rise[2] & ~(|rise[4:3]);
  assign act_right = rise[1] & ~(|rise[4:2]);
  assign act_left  = rise[0] & ~(|rise[4:1]);

  assign code_ok    = ({digit[2], digit[1], digit[0]} == PASSWORD);
  assign fail_inc   = fail_cnt + 3'd1;
  assign fail_hit   = (fail_inc == FAIL_LIMIT);
  assign timer_done = (timer == 8'd0);
  assign load_timer = ((state == S_LOCKED) && (state_nxt == S_OPENING)) ||
                      ((state == S_OPEN)   && (state_nxt == S_CLOSING));

  always_comb begin
    case (cursor)
      2'd1:    sel_digit = digit[1];
      2'd2:    sel_digit = digit[2];
      default: sel_digit = digit[0];
    endcase
  end

  assign digit_inc = (sel_digit >= 4'd9) ? 4'd0 : sel_digit + 4'd1;
  assign digit_dec = (sel_digit == 4'd0) ? 4'd9 : sel_digit - 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_LOCKED;
      Motor    <= 3'b000;
      Lock     <= 1'b1;
      btn_prev <= 5'd0;
    end else begin
      state    <= state_nxt;
      Motor    <= motor_nxt;
      Lock     <= lock_nxt;
      btn_prev <= btn;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOCKED:  if (act_enter) state_nxt = code_ok ? S_OPENING : (fail_hit ? S_ALARM : S_LOCKED);
      S_OPENING: if (timer_done) state_nxt = S_OPEN;
      S_OPEN:    if (act_enter) state_nxt = S_CLOSING;
      S_CLOSING: if (timer_done) state_nxt = S_LOCKED;
      S_ALARM:   state_nxt = S_ALARM;
      default:   state_nxt = S_LOCKED;
    endcase
  end

  // Outputs decode the next state so they register together with it.
  always_comb begin
    motor_nxt = 3'b000;
    lock_nxt  = 1'b1;
    case (state_nxt)
      S_OPENING: motor_nxt = 3'b001;
      S_OPEN:    lock_nxt  = 1'b0;
      S_CLOSING: motor_nxt = 3'b010;
      S_ALARM:   motor_nxt = 3'b100;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer    <= 8'd0;
      cursor   <= 2'd0;
      fail_cnt <= 3'd0;
      for (int i = 0; i < 3; i++) digit[i] <= 4'd0;
    end else begin
      if (load_timer)       timer <= MOVE_LOAD;
      else if (!timer_done) timer <= timer - 8'd1;

      if (state == S_LOCKED) begin
        if (act_enter) begin
          if (code_ok) fail_cnt <= 3'd0;
          else begin
            fail_cnt <= fail_inc;
            for (int i = 0; i < 3; i++) digit[i] <= 4'd0;
          end
        end else if (act_up || act_down) begin
          for (int i = 0; i < 3; i++)
            if (cursor == 2'(i)) digit[i] <= act_up ? digit_inc : digit_dec;
        end else if (act_right) begin
          cursor <= (cursor == 2'd2) ? 2'd0 : cursor + 2'd1;
        end else if (act_left) begin
          cursor <= (cursor == 2'd0) ? 2'd2 : cursor - 2'd1;
        end
      end else if ((state == S_CLOSING) && timer_done) begin
        cursor <= 2'd0;
        for (int i = 0; i < 3; i++) digit[i] <= 4'd0;
      end
    end
  end

  assign Value0 = digit[0];
  assign Value1 = digit[1];
  assign Value2 = digit[2];

endmodule

// File: tb/tb_blk_431c31.sv
// Bench for the keypad lock: a behavioural model pushes expected outputs to a
// scoreboard each cycle, plus directed checks of the key scenarios.
module tb_blk_431c31;

  localparam logic [4:0] B_L = 5'b00001, B_R = 5'b00010, B_D = 5'b00100,
                         B_U = 5'b01000, B_E = 5'b10000;

  logic       clk, rst;
  logic       Left, Right, Up, Down, Enter;
  logic [3:0] Value0, Value1, Value2;
  logic [2:0] Motor;
  logic       Lock;

  blk_431c31 dut (
    .clk(clk), .rst(rst), .Left(Left), .Right(Right), .Up(Up), .Down(Down),
    .Enter(Enter), .Value0(Value0), .Value1(Value1), .Value2(Value2),
    .Motor(Motor), .Lock(Lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] v0, v1, v2;
    logic [2:0] motor;
    logic       lock;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // model: 0 locked, 1 opening, 2 open, 3 closing, 4 alarm
  int         ms, mcur, mfail, mcnt;
  logic [3:0] md [3];
  logic [4:0] mprev;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    ms = 0; mcur = 0; mfail = 0; mcnt = 0; mprev = 5'd0;
    for (int i = 0; i < 3; i++) md[i] = 4'd0;
  endtask

  task automatic model_step(input logic [4:0] b);
    logic [4:0] r;
    r = b & ~mprev;
    mprev = b;
    case (ms)
      0: begin
        if (r[4]) begin
          if ({md[2], md[1], md[0]} == 12'h080) begin
            ms = 1; mcnt = 0; mfail = 0;
          end else begin
            mfail++;
            for (int i = 0; i < 3; i++) md[i] = 4'd0;
            if (mfail == 3) ms = 4;
          end
        end else if (r[3]) md[mcur] = 4'((int'(md[mcur]) + 1) % 10);
        else if (r[2])     md[mcur] = 4'((int'(md[mcur]) + 9) % 10);
        else if (r[1])     mcur = (mcur + 1) % 3;
        else if (r[0])     mcur = (mcur + 2) % 3;
      end
      1: begin mcnt++; if (mcnt == 8) ms = 2; end
      2: if (r[4]) begin ms = 3; mcnt = 0; end
      3: begin
        mcnt++;
        if (mcnt == 8) begin
          ms = 0; mcur = 0;
          for (int i = 0; i < 3; i++) md[i] = 4'd0;
        end
      end
      default: ;
    endcase
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.v0 = md[0]; e.v1 = md[1]; e.v2 = md[2];
    e.lock  = (ms != 2);
    e.motor = (ms == 1) ? 3'b001 : (ms == 3) ? 3'b010 : (ms == 4) ? 3'b100 : 3'b000;
    return e;
  endfunction

  task automatic tick(input logic [4:0] b);
    exp_t e;
    @(negedge clk);
    {Enter, Up, Down, Right, Left} = b;
    model_step(b);
    sb.push_back(model_out());
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("sb_v0", {8'd0, Value0}, {8'd0, e.v0});
    chk("sb_v1", {8'd0, Value1}, {8'd0, e.v1});
    chk("sb_v2", {8'd0, Value2}, {8'd0, e.v2});
    chk("sb_motor", {9'd0, Motor}, {9'd0, e.motor});
    chk("sb_lock", {11'd0, Lock}, {11'd0, e.lock});
  endtask

  task automatic press(input logic [4:0] b);
    tick(b);
    tick(5'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    {Enter, Up, Down, Right, Left} = 5'd0;
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_digits", {Value2, Value1, Value0}, 12'h000);
    chk("rst_motor", {9'd0, Motor}, 12'h000);
    chk("rst_lock", {11'd0, Lock}, 12'h001);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    {Enter, Up, Down, Right, Left} = 5'd0;
    model_reset();
    do_reset();

    // cursor wrap
    repeat (5) press(B_R);
    repeat (3) press(B_L);
    press(B_U);
    chk("cursor_wrap", {Value2, Value1, Value0}, 12'h100);

    // digit wrap at cursor 1
    press(B_L);
    press(B_U); chk("dwrap_1", {8'd0, Value1}, 12'd1);
    press(B_U); chk("dwrap_2", {8'd0, Value1}, 12'd2);
    press(B_D); chk("dwrap_3", {8'd0, Value1}, 12'd1);
    press(B_D); chk("dwrap_4", {8'd0, Value1}, 12'd0);
    press(B_D); chk("dwrap_5", {8'd0, Value1}, 12'd9);
    press(B_D); chk("dwrap_6", {8'd0, Value1}, 12'd8);

    // wrong code clears digits, cursor stays at 1
    press(B_E);
    chk("wrong_digits", {Value2, Value1, Value0}, 12'h000);
    chk("wrong_lock", {11'd0, Lock}, 12'd1);
    chk("wrong_motor", {9'd0, Motor}, 12'd0);
    press(B_U);
    chk("wrong_cursor", {Value2, Value1, Value0}, 12'h010);

    // enter 0,8,0 and run a full open/close cycle
    repeat (3) press(B_D);
    chk("code_set", {Value2, Value1, Value0}, 12'h080);
    tick(B_E);
    chk("open_start", {9'd0, Motor}, 12'd1);
    for (int i = 0; i < 7; i++) tick(5'd0);
    chk("open_last", {9'd0, Motor}, 12'd1);
    tick(5'd0);
    chk("open_lock", {11'd0, Lock}, 12'd0);
    chk("open_motor", {9'd0, Motor}, 12'd0);
    press(B_U);
    chk("open_ignore", {Value2, Value1, Value0}, 12'h080);
    tick(B_E);
    chk("close_start", {9'd0, Motor}, 12'd2);
    for (int i = 0; i < 7; i++) tick(5'd0);
    chk("close_last", {9'd0, Motor}, 12'd2);
    tick(5'd0);
    chk("closed_lock", {11'd0, Lock}, 12'd1);
    chk("closed_digits", {Value2, Value1, Value0}, 12'h000);

    // simultaneous Up+Right held: one increment at cursor 0, cursor unchanged
    repeat (3) tick(B_U | B_R);
    tick(5'd0);
    chk("simul_held", {Value2, Value1, Value0}, 12'h001);
    press(B_U);
    chk("simul_cursor", {Value2, Value1, Value0}, 12'h002);
    press(B_D | B_L);
    chk("prio_down_left", {Value2, Value1, Value0}, 12'h001);

    // alarm after three wrong codes
    repeat (3) press(B_E);
    chk("alarm_motor", {9'd0, Motor}, 12'h004);
    press(B_U); press(B_E); press(B_R);
    chk("alarm_hold", {9'd0, Motor}, 12'h004);
    chk("alarm_lock", {11'd0, Lock}, 12'd1);
    do_reset();

    // reset in the middle of opening
    press(B_R);
    repeat (8) press(B_U);
    tick(B_E);
    tick(5'd0); tick(5'd0);
    chk("mid_open", {9'd0, Motor}, 12'd1);
    do_reset();

    // button held across reset release acts on the first edge
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    Up = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    tick(B_U);
    chk("rel_first_edge", {Value2, Value1, Value0}, 12'h001);
    tick(5'd0);

    // random traffic with periodic resets
    for (int i = 0; i < 400; i++) begin
      if (i % 80 == 79) do_reset();
      else if ($urandom_range(0, 2) == 0) tick(5'($urandom_range(0, 31)));
      else tick(5'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
